// File: rtl/mastermind_pkg.sv
// Shared constants and FSM state encoding for the Mastermind controller.
// Imported by mastermind_scorer and mastermind_game_ctrl.
package mastermind_pkg;

  localparam int NUM_DIGITS  = 4;
  localparam int DIGIT_W     = 3;
  localparam int NUM_COLOURS = 8;

  typedef enum logic [2:0] {
    ENTRY,
    SCORE_EXACT,
    SCORE_COLOUR,
    RESULT,
    WIN,
    LOSE
  } state_t;

endpackage

// File: rtl/mastermind_scorer.sv
// Multi-cycle Mastermind scorer: snapshots secret and guess on start_i,
// one exact pass, then one partial-count pass per colour.
// Ports: clk_i/rst_i, start_i, secret_i/guess_i ({x0..x3}, x0 in MSBs),
//        last_o (final colour cycle), done_o, exact_o, partial_o.
module mastermind_scorer
  import mastermind_pkg::*;
#(
  parameter int DIGIT_W = 3
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            start_i,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]   secret_i,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]   guess_i,
  output logic                            last_o,
  output logic                            done_o,
  output logic [2:0]                      exact_o,
  output logic [2:0]                      partial_o
);

  typedef enum logic [1:0] {
    P_IDLE,
    P_EXACT,
    P_COL,
    P_DONE
  } phase_t;

  phase_t                          phase_q;
  logic [NUM_DIGITS*DIGIT_W-1:0]   sec_q;
  logic [NUM_DIGITS*DIGIT_W-1:0]   gss_q;
  logic [NUM_DIGITS-1:0]           mask_q;
  logic [DIGIT_W-1:0]              col_q;
  logic [2:0]                      exact_q;
  logic [2:0]                      partial_q;

  logic [NUM_DIGITS-1:0]           eq_d;
  logic [2:0]                      ex_cnt;
  logic [2:0]                      cs;
  logic [2:0]                      cg;
  logic [2:0]                      mn;

  always_comb begin
    eq_d   = '0;
    ex_cnt = '0;
    cs     = '0;
    cg     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      eq_d[i] = sec_q[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W] ==
                gss_q[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W];
      ex_cnt  = ex_cnt + {2'b00, eq_d[i]};
      if (mask_q[i] &&
          sec_q[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W] == col_q)
        cs = cs + 3'd1;
      if (mask_q[i] &&
          gss_q[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W] == col_q)
        cg = cg + 3'd1;
    end
    mn = (cs < cg) ? cs : cg;
  end

  assign last_o    = (phase_q == P_COL) && (col_q == '1);
  assign done_o    = (phase_q == P_DONE);
  assign exact_o   = exact_q;
  assign partial_o = partial_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q   <= P_IDLE;
      sec_q     <= '0;
      gss_q     <= '0;
      mask_q    <= '0;
      col_q     <= '0;
      exact_q   <= '0;
      partial_q <= '0;
    end else begin
      unique case (phase_q)
        P_IDLE: begin
          if (start_i) begin
            sec_q     <= secret_i;
            gss_q     <= guess_i;
            exact_q   <= '0;
            partial_q <= '0;
            col_q     <= '0;
            phase_q   <= P_EXACT;
          end
        end
        P_EXACT: begin
          exact_q <= ex_cnt;
          mask_q  <= ~eq_d;
          phase_q <= P_COL;
        end
        P_COL: begin
          partial_q <= partial_q + mn;
          col_q     <= col_q + 1'b1;
          if (col_q == '1)
            phase_q <= P_DONE;
        end
        P_DONE: phase_q <= P_IDLE;
        default: phase_q <= P_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mastermind_game_ctrl.sv
// Mastermind game controller: digit entry, submit/score sequencing,
// attempt counting and win/lose. Ports: clock, rst, key pulses,
// sw_digit, secret; guess digits, cursor, score, tries, busy, win, lose.
module mastermind_game_ctrl
  import mastermind_pkg::*;
#(
  parameter int DIGIT_W   = 3,
  parameter int MAX_TRIES = 10
) (
  input  logic                   MAX10_CLK1_50,
  input  logic                   rst,
  input  logic                   key_next,
  input  logic                   key_submit,
  input  logic [DIGIT_W-1:0]     sw_digit,
  input  logic [4*DIGIT_W-1:0]   secret,
  output logic [DIGIT_W-1:0]     d0,
  output logic [DIGIT_W-1:0]     d1,
  output logic [DIGIT_W-1:0]     d2,
  output logic [DIGIT_W-1:0]     d3,
  output logic [1:0]             cursor,
  output logic [2:0]             exact,
  output logic [2:0]             partial,
  output logic [3:0]             tries,
  output logic                   busy,
  output logic                   win,
  output logic                   lose
);

  state_t               state_q;
  logic [DIGIT_W-1:0]   dig_q [NUM_DIGITS];
  logic [DIGIT_W-1:0]   prev_sw_q;
  logic [1:0]           cursor_q;
  logic [2:0]           exact_q;
  logic [2:0]           partial_q;
  logic [3:0]           tries_q;
  logic [3:0]           tries_d;
  logic                 busy_q;
  logic                 win_q;
  logic                 lose_q;

  logic                 sc_start;
  logic                 sc_last;
  logic                 sc_done;
  logic [2:0]           sc_exact;
  logic [2:0]           sc_partial;

  assign sc_start = (state_q == ENTRY) && key_submit;
  assign tries_d  = tries_q + 4'd1;

  mastermind_scorer #(
    .DIGIT_W (DIGIT_W)
  ) u_scorer (
    .clk_i     (MAX10_CLK1_50),
    .rst_i     (rst),
    .start_i   (sc_start),
    .secret_i  (secret),
    .guess_i   ({dig_q[0], dig_q[1], dig_q[2], dig_q[3]}),
    .last_o    (sc_last),
    .done_o    (sc_done),
    .exact_o   (sc_exact),
    .partial_o (sc_partial)
  );

  always_ff @(posedge MAX10_CLK1_50 or posedge rst) begin
    if (rst) begin
      state_q   <= ENTRY;
      for (int i = 0; i < NUM_DIGITS; i++)
        dig_q[i] <= '0;
      prev_sw_q <= '0;
      cursor_q  <= '0;
      exact_q   <= '0;
      partial_q <= '0;
      tries_q   <= '0;
      busy_q    <= 1'b0;
      win_q     <= 1'b0;
      lose_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ENTRY: begin
          if (key_submit) begin
            busy_q  <= 1'b1;
            state_q <= SCORE_EXACT;
          end else begin
            if (sw_digit != prev_sw_q) begin
              dig_q[cursor_q] <= sw_digit;
              prev_sw_q       <= sw_digit;
            end
            if (key_next)
              cursor_q <= cursor_q + 2'd1;
          end
        end
        SCORE_EXACT: state_q <= SCORE_COLOUR;
        SCORE_COLOUR: begin
          if (sc_last)
            state_q <= RESULT;
        end
        RESULT: begin
          if (sc_done) begin
            exact_q   <= sc_exact;
            partial_q <= sc_partial;
            tries_q   <= tries_d;
            busy_q    <= 1'b0;
            if (sc_exact == 3'd4) begin
              win_q   <= 1'b1;
              state_q <= WIN;
            end else if (tries_d == 4'(MAX_TRIES)) begin
              lose_q  <= 1'b1;
              state_q <= LOSE;
            end else begin
              cursor_q <= '0;
              state_q  <= ENTRY;
            end
          end
        end
        WIN, LOSE: begin
          if (key_submit) begin
            for (int i = 0; i < NUM_DIGITS; i++)
              dig_q[i] <= '0;
            cursor_q  <= '0;
            exact_q   <= '0;
            partial_q <= '0;
            tries_q   <= '0;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
            prev_sw_q <= sw_digit;
            state_q   <= ENTRY;
          end
        end
        default: state_q <= ENTRY;
      endcase
    end
  end

  assign d0      = dig_q[0];
  assign d1      = dig_q[1];
  assign d2      = dig_q[2];
  assign d3      = dig_q[3];
  assign cursor  = cursor_q;
  assign exact   = exact_q;
  assign partial = partial_q;
  assign tries   = tries_q;
  assign busy    = busy_q;
  assign win     = win_q;
  assign lose    = lose_q;

endmodule

// File: tb/tb_mastermind_game_ctrl.sv
// Directed bench for mastermind_game_ctrl with a result scoreboard
// fed by a pairing-based reference scorer.
module tb_mastermind_game_ctrl;

  logic        clk;
  logic        rst;
  logic        key_next;
  logic        key_submit;
  logic [2:0]  sw_digit;
  logic [11:0] secret;
  logic [2:0]  d0, d1, d2, d3;
  logic [1:0]  cursor;
  logic [2:0]  exact, partial;
  logic [3:0]  tries;
  logic        busy, win, lose;

  typedef struct {
    logic [2:0] ex;
    logic [2:0] pa;
    logic [3:0] tr;
    logic       w;
    logic       l;
  } exp_t;

  exp_t        sbq[$];
  int          ncmp = 0;
  int          nerr = 0;
  int          mt = 0;
  logic [2:0]  g [4];

  mastermind_game_ctrl #(.DIGIT_W(3), .MAX_TRIES(10)) dut (
    .MAX10_CLK1_50 (clk),
    .rst           (rst),
    .key_next      (key_next),
    .key_submit    (key_submit),
    .sw_digit      (sw_digit),
    .secret        (secret),
    .d0            (d0),
    .d1            (d1),
    .d2            (d2),
    .d3            (d3),
    .cursor        (cursor),
    .exact         (exact),
    .partial       (partial),
    .tries         (tries),
    .busy          (busy),
    .win           (win),
    .lose          (lose)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [11:0] pack4(input logic [2:0] a,
      input logic [2:0] b, input logic [2:0] c, input logic [2:0] d);
    return {a, b, c, d};
  endfunction

  // Greedy pairing: each unmatched guess digit claims the first
  // unclaimed unmatched secret digit of the same colour.
  function automatic logic [5:0] ref_score(input logic [11:0] s,
                                           input logic [11:0] gu);
    logic [2:0] sd [4];
    logic [2:0] gd [4];
    bit         su [4];
    bit         gm [4];
    logic [2:0] ex;
    logic [2:0] pa;
    ex = 0;
    pa = 0;
    for (int i = 0; i < 4; i++) begin
      sd[i] = s[(3-i)*3 +: 3];
      gd[i] = gu[(3-i)*3 +: 3];
      su[i] = (sd[i] == gd[i]);
      gm[i] = su[i];
      if (su[i]) ex++;
    end
    for (int i = 0; i < 4; i++) begin
      if (!gm[i]) begin
        for (int j = 0; j < 4; j++) begin
          if (!gm[i] && !su[j] && sd[j] == gd[i]) begin
            su[j] = 1;
            gm[i] = 1;
            pa++;
          end
        end
      end
    end
    return {ex, pa};
  endfunction

  task automatic enter_guess(input logic [2:0] v0, input logic [2:0] v1,
                             input logic [2:0] v2, input logic [2:0] v3);
    logic [2:0] v [4];
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    for (int i = 0; i < 4; i++) begin
      sw_digit = v[i] + 3'd1;
      tick();
      sw_digit = v[i];
      tick();
      key_next = 1'b1;
      tick();
      key_next = 1'b0;
      g[i] = v[i];
    end
  endtask

  // Submit, check the busy window and latency, then pop the scoreboard.
  // With disturb set, key_next / secret / switch change mid-scoring.
  task automatic submit(input bit disturb, input logic [11:0] alt_sec,
                        input logic [1:0] cur_exp);
    exp_t       e;
    exp_t       o;
    logic [5:0] r;
    logic [2:0] ex_before;
    bit         bsy_ok;
    r    = ref_score(secret, pack4(g[0], g[1], g[2], g[3]));
    mt++;
    e.ex = r[5:3];
    e.pa = r[2:0];
    e.tr = 4'(mt);
    e.w  = (r[5:3] == 3'd4);
    e.l  = !e.w && (mt == 10);
    sbq.push_back(e);
    ex_before  = exact;
    key_submit = 1'b1;
    tick();
    key_submit = 1'b0;
    bsy_ok = 1;
    for (int n = 1; n <= 9; n++) begin
      tick();
      if (busy !== 1'b1) bsy_ok = 0;
      if (disturb && n == 3) begin
        key_next = 1'b1;
        secret   = alt_sec;
        sw_digit = 3'd3;
      end
      if (disturb && n == 4) begin
        key_next = 1'b0;
        chk("cursor_frozen_busy", cursor, cur_exp);
      end
    end
    chk("busy_window", bsy_ok, 1);
    chk("exact_held_k9", exact, ex_before);
    tick();
    chk("busy_fall_k10", busy, 0);
    o.ex = exact; o.pa = partial; o.tr = tries; o.w = win; o.l = lose;
    if (sbq.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sbq.pop_front();
      chk("sb_exact", o.ex, e.ex);
      chk("sb_partial", o.pa, e.pa);
      chk("sb_tries", o.tr, e.tr);
      chk("sb_win", o.w, e.w);
      chk("sb_lose", o.l, e.l);
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_d"}, {d0, d1, d2, d3}, 0);
    chk({tag, "_cur"}, cursor, 0);
    chk({tag, "_score"}, {exact, partial}, 0);
    chk({tag, "_tries"}, tries, 0);
    chk({tag, "_flags"}, {busy, win, lose}, 0);
  endtask

  task automatic restart();
    key_submit = 1'b1;
    tick();
    key_submit = 1'b0;
    mt = 0;
  endtask

  initial begin
    rst        = 1'b1;
    key_next   = 1'b0;
    key_submit = 1'b0;
    sw_digit   = 3'd0;
    secret     = '0;
    #25;
    chk_cleared("reset");
    @(negedge clk);
    rst = 1'b0;
    tick();

    // 1: digit entry and cursor wrap
    sw_digit = 3'd5;
    tick();
    chk("t1_d0", d0, 5);
    key_next = 1'b1;
    tick();
    key_next = 1'b0;
    chk("t1_cur1", cursor, 1);
    tick();
    chk("t1_d1_nomove_load", d1, 0);
    sw_digit = 3'd2;
    tick();
    chk("t1_d1", d1, 2);
    chk("t1_d0_kept", d0, 5);
    for (int i = 0; i < 3; i++) begin
      key_next = 1'b1;
      tick();
    end
    key_next = 1'b0;
    chk("t1_wrap", cursor, 0);

    // 2: winning guess, cursor left at 1
    secret = pack4(3'd1, 3'd2, 3'd3, 3'd4);
    enter_guess(3'd1, 3'd2, 3'd3, 3'd4);
    key_next = 1'b1;
    tick();
    key_next = 1'b0;
    submit(0, '0, 2'd0);
    chk("t2_const", {exact, partial, tries, win}, {3'd4, 3'd0, 4'd1, 1'b1});
    key_next = 1'b1;
    sw_digit = 3'd6;
    tick();
    key_next = 1'b0;
    chk("t2_next_ignored", cursor, 1);
    chk("t2_digits_frozen", {d0, d1, d2, d3},
        {3'd1, 3'd2, 3'd3, 3'd4});
    chk("t2_win_held", win, 1);
    restart();
    chk_cleared("t2_restart");
    tick();
    chk("t2_prev_sw_synced", d0, 0);

    // 3: reversed guess
    enter_guess(3'd4, 3'd3, 3'd2, 3'd1);
    submit(0, '0, 2'd0);
    chk("t3_const", {exact, partial, tries}, {3'd0, 3'd4, 4'd1});
    chk("t3_cursor", cursor, 0);
    chk("t3_no_flags", {win, lose}, 0);

    // 4: duplicate colours
    secret = pack4(3'd1, 3'd1, 3'd2, 3'd2);
    enter_guess(3'd1, 3'd2, 3'd1, 3'd5);
    submit(0, '0, 2'd0);
    chk("t4_const", {exact, partial}, {3'd1, 3'd2});

    // 5: resubmit until the tenth result loses
    for (int i = 0; i < 8; i++)
      submit(0, '0, 2'd0);
    chk("t5_lose", {lose, win, tries}, {1'b1, 1'b0, 4'd10});
    key_next = 1'b1;
    tick();
    key_next = 1'b0;
    chk("t5_next_ignored", cursor, 0);
    chk("t5_lose_held", lose, 1);
    restart();
    chk_cleared("t5_restart");

    // 6a: events during busy use the snapshot
    secret = pack4(3'd5, 3'd6, 3'd7, 3'd0);
    enter_guess(3'd5, 3'd6, 3'd0, 3'd7);
    key_next = 1'b1;
    tick();
    key_next = 1'b0;
    submit(1, pack4(3'd5, 3'd6, 3'd0, 3'd7), 2'd1);
    chk("t6_snapshot", {exact, partial, win}, {3'd2, 3'd2, 1'b0});
    chk("t6_cursor_reset", cursor, 0);
    tick();
    chk("t6_sw_applied", d0, 3);

    // 6b: reset in the middle of SCORE_COLOUR
    key_submit = 1'b1;
    tick();
    key_submit = 1'b0;
    tick();
    tick();
    tick();
    chk("t6_busy_pre_rst", busy, 1);
    #3;
    rst = 1'b1;
    #1;
    chk_cleared("t6_rst");
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("t6_idle_after_rst", busy, 0);
    sw_digit = 3'd6;
    tick();
    chk("t6_entry_load", d0, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
